clock_mode_controller: RTL and testbench
========================================

# clock_mode_controller

Control-plane sequencer for the DE10 alarm clock. It debounces the two raw push buttons and runs the display-mode FSM (CLOCK/ALARM/TIMER/STOPWATCH). It turns set-button presses into single-cycle increment, run and clear strobes for the timekeeping datapath. It also owns the alarm arm/ring/snooze state machine and the buzzer cadence; the counters and 7-segment decode stay in the datapath.

## Interface
- DEBOUNCE_CYCLES, 2000000, cycles a synchronized button level must hold before the debounced level changes (40 ms at 50 MHz).
- RING_SECONDS, 60, tick_1hz pulses of ringing before auto-stop.
- SNOOZE_SECONDS, 300, tick_1hz pulses spent in SNOOZE before re-ring.
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset, synchronous, active-high. One clock; no other reset.
- tick_1hz  in  1  one-cycle pulse once per second from the datapath.
- btn_mode_n  in  1  raw mode button, active-low, asynchronous.
- btn_set_n  in  1  raw set button, active-low, asynchronous.
- sw_edit  in  1  edit enable switch.
- sw_field  in  2  01 = hours, 10 = minutes; 00 and 11 = no field.
- time_hh, time_mm, time_ss  in  8 each  current time.
- alarm_hh, alarm_mm  in  8 each  alarm setpoint.
- mode  out  2  0 CLOCK, 1 ALARM, 2 TIMER, 3 STOPWATCH.
- inc_hh, inc_mm  out  1 each  one-cycle increment strobes.
- inc_target  out  2  copy of mode, valid while either inc strobe is high.
- sw_run  out  1  stopwatch run level.
- sw_clear  out  1  one-cycle stopwatch clear strobe.
- alarm_armed, ring, buzzer  out  1 each.

## Operation
- Debounce: each button passes through a 2-flop synchronizer, then a stability counter. The debounced level follows the synchronized level once the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce resets the count. A press event is a one-cycle pulse on a debounced 1->0 transition.
- Mode press with sw_edit=0: mode advances 3->0 wrap. With sw_edit=1 it is ignored.
- Set press in modes 0–2 with sw_edit=1: sw_field 01 pulses inc_hh; sw_field 10 pulses inc_mm; other values do nothing.
- An inc pulse while mode=1 sets alarm_armed and moves the alarm FSM from IDLE to ARMED.
- Set press in mode 1 with sw_edit=0: toggles arming. Disarm from any alarm state goes to IDLE, drops ring, and clears the ring and snooze counters.
- Set press in mode 3: with sw_edit=0 it toggles sw_run; with sw_edit=1 it pulses sw_clear and forces sw_run=0.
- Alarm FSM states: IDLE, ARMED, RINGING, SNOOZE. alarm_armed=1 in every state except IDLE.
- ARMED->RINGING: on a tick_1hz cycle with time_hh==alarm_hh, time_mm==alarm_mm and time_ss==0.
- RINGING: ring=1. Each tick_1hz increments the ring counter; after the tick that reaches RING_SECONDS, the FSM returns to ARMED.
- Any set press while RINGING is a dismiss: go to ARMED. The press is consumed, so it produces no toggle, inc or stopwatch action.
- buzzer = ring AND a phase bit. The phase bit is 1 on RINGING entry and toggles on each tick_1hz (1 s on, 1 s off).
- Event priority within one cycle: rst > disarm > dismiss > alarm match > auto-stop. A mode press and a set press in the same cycle: mode press is processed, set press is dropped.

## Timing
- Strobes and all outputs are registered. A strobe is high exactly one cycle, in the cycle after the press event.
- Raw edge to strobe: 2 (synchronizer) + DEBOUNCE_CYCLES + 1 cycles.
- ring rises in the cycle after the matching tick_1hz.
- Reset values: mode=0; inc_hh=0, inc_mm=0, inc_target=0; sw_run=0, sw_clear=0; alarm FSM IDLE, so alarm_armed=0, ring=0, buzzer=0; debounced levels = released (1); all counters 0.
- Reset mid-debounce or mid-ring aborts the activity on the next clock edge. A button held through reset does not generate a press event until it has been released and pressed again.

## Configuration
- SNOOZE_EN defined: a mode press while RINGING goes to SNOOZE and does not change mode. SNOOZE counts SNOOZE_SECONDS ticks, then re-enters RINGING with the ring counter cleared. Disarm from SNOOZE goes to IDLE.
- SNOOZE_EN undefined: the SNOOZE state and its counter are absent. A mode press while RINGING is an ordinary mode advance, and ringing continues.

## Structure
- Package clock_ctrl_pkg holds:
  - mode_t enum (CLOCK, ALARM, TIMER, STOPWATCH);
  - alarm_state_t enum (IDLE, ARMED, RINGING, SNOOZE);
  - field codes FIELD_HH=2'b01, FIELD_MM=2'b10.
- One sub-module, btn_debounce (synchronizer, stability counter, press pulse), instantiated once per button.

## Test plan
- Run with DEBOUNCE_CYCLES=4. A 3-cycle low glitch on btn_mode_n -> no event, mode stays 0. A 10-cycle low press -> mode=1, 7 cycles after the raw edge.
- Four clean mode presses with sw_edit=0 -> mode steps 1,2,3,0. The same presses with sw_edit=1 -> mode unchanged.
- mode=1, sw_edit=1, sw_field=10, one set press -> exactly one inc_mm pulse with inc_target=1, and alarm_armed=1.
- Armed at 07:30; drive time 07:30:00 with tick_1hz -> ring=1 next cycle and buzzer alternates per tick. Hold for RING_SECONDS=3 ticks -> back to ARMED, ring=0.
- While ringing, set press in mode 3 -> dismissed, sw_run stays 0. While ringing with SNOOZE_EN and SNOOZE_SECONDS=2, a mode press -> mode unchanged, ring=0 for 2 ticks, then ring=1.
- Assert rst while ringing with sw_run=1 -> next cycle every output is at its reset value.

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_ctrl_pkg
// Description : Shared types and codes for the alarm-clock control plane:
//               display modes, alarm FSM states, edit-field codes and the
//               mode-advance helper.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_ctrl_pkg;

   typedef enum logic [1:0] {
      CLOCK     = 2'd0,
      ALARM     = 2'd1,
      TIMER     = 2'd2,
      STOPWATCH = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      RINGING = 2'd2,
      SNOOZE  = 2'd3
   } alarm_state_t;

   // Alarm FSM encodings as plain constants for the state register
   localparam logic [1:0] ST_IDLE    = IDLE;
   localparam logic [1:0] ST_ARMED   = ARMED;
   localparam logic [1:0] ST_RINGING = RINGING;
   localparam logic [1:0] ST_SNOOZE  = SNOOZE;

   // sw_field codes selecting which time field a set press increments
   localparam logic [1:0] FIELD_HH = 2'b01;
   localparam logic [1:0] FIELD_MM = 2'b10;

   // Display mode sequence CLOCK -> ALARM -> TIMER -> STOPWATCH -> CLOCK
   function automatic logic [1:0] next_mode(input logic [1:0] m);
      return m + 2'd1;
   endfunction

endpackage : clock_ctrl_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Active-low push-button conditioner: 2-flop synchronizer,
//               stability counter and a one-cycle press pulse on a debounced
//               1->0 transition. A button held through reset produces no
//               press until it has been seen released.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 2000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n,
   output logic press
);

   localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic [1:0]    sync_vld;   // sync2 carries a real post-reset sample once bit 1 is set
   logic          level;      // debounced level, 1 = released
   logic          seen_rel;   // a released level has been observed since reset
   logic [CW-1:0] cnt;

   // Synchronize, qualify stability and emit the press pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1    <= 1'b1;
         sync2    <= 1'b1;
         sync_vld <= 2'b00;
         level    <= 1'b1;
         seen_rel <= 1'b0;
         cnt      <= '0;
         press    <= 1'b0;
      end else begin
         sync1    <= btn_n;
         sync2    <= sync1;
         sync_vld <= {sync_vld[0], 1'b1};
         press    <= 1'b0;
         if (sync_vld[1] && sync2) begin
            seen_rel <= 1'b1;
         end
         if (sync2 != level) begin
            if (cnt == CNT_LAST) begin
               level <= sync2;
               cnt   <= '0;
               if (!sync2 && seen_rel) begin
                  press <= 1'b1;
               end
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule : btn_debounce
`default_nettype wire

// File: rtl/clock_mode_controller.sv
`default_nettype none
// ============================================================================
// Module      : clock_mode_controller
// Description : Control-plane sequencer for the alarm clock. Debounces the
//               mode and set buttons, runs the display-mode FSM, produces
//               increment / stopwatch strobes and owns the alarm
//               arm/ring/snooze FSM plus buzzer cadence.
//               Optional feature macro: SNOOZE_EN (mode press while ringing
//               snoozes instead of advancing mode).
// Revision    : 1.0 - initial release
// ============================================================================
module clock_mode_controller
   import clock_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 2000000,
   parameter int RING_SECONDS    = 60,
   parameter int SNOOZE_SECONDS  = 300
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       btn_mode_n,
   input  logic       btn_set_n,
   input  logic       sw_edit,
   input  logic [1:0] sw_field,
   input  logic [7:0] time_hh,
   input  logic [7:0] time_mm,
   input  logic [7:0] time_ss,
   input  logic [7:0] alarm_hh,
   input  logic [7:0] alarm_mm,
   output logic [1:0] mode,
   output logic       inc_hh,
   output logic       inc_mm,
   output logic [1:0] inc_target,
   output logic       sw_run,
   output logic       sw_clear,
   output logic       alarm_armed,
   output logic       ring,
   output logic       buzzer
);

   localparam int RW = (RING_SECONDS < 2) ? 1 : $clog2(RING_SECONDS + 1);
   localparam logic [RW-1:0] RING_LAST = RW'(RING_SECONDS - 1);

   if (DEBOUNCE_CYCLES < 1 || RING_SECONDS < 1 || SNOOZE_SECONDS < 1) begin : g_bad_params
      $error("clock_mode_controller: all timing parameters must be >= 1");
   end

   // ---------------------------------------------------------------------
   // Button conditioning
   // ---------------------------------------------------------------------
   logic mode_press;
   logic set_press;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
      .clk   (clk),
      .rst   (rst),
      .btn_n (btn_mode_n),
      .press (mode_press)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set (
      .clk   (clk),
      .rst   (rst),
      .btn_n (btn_set_n),
      .press (set_press)
   );

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [1:0]    state;
   logic [RW-1:0] ring_cnt;
   logic          phase;

   logic [1:0]    state_nxt;
   logic [RW-1:0] ring_cnt_nxt;
   logic          phase_nxt;
   logic [1:0]    mode_nxt;
   logic          inc_hh_nxt;
   logic          inc_mm_nxt;
   logic [1:0]    inc_target_nxt;
   logic          sw_run_nxt;
   logic          sw_clear_nxt;

`ifdef SNOOZE_EN
   localparam int SW = (SNOOZE_SECONDS < 2) ? 1 : $clog2(SNOOZE_SECONDS + 1);
   localparam logic [SW-1:0] SNZ_LAST = SW'(SNOOZE_SECONDS - 1);
   logic [SW-1:0] snz_cnt;
   logic [SW-1:0] snz_cnt_nxt;
`endif

   logic set_evt;
   logic in_ring;
   logic alarm_set;
   logic disarm;
   logic arm_toggle;
   logic dismiss;
   logic act_set;
   logic snooze_req;
   logic alarm_match;
   logic arm_by_inc;

   // Decode button events and compute the next control/alarm state
   always_comb begin
      // A simultaneous mode press drops the set press
      set_evt     = set_press & ~mode_press;
      in_ring     = (state == ST_RINGING);
      alarm_set   = set_evt & (mode == ALARM) & ~sw_edit;
      disarm      = alarm_set & (state != ST_IDLE);
      arm_toggle  = alarm_set & (state == ST_IDLE);
      // Set presses while ringing are consumed as a dismiss unless they disarm
      dismiss     = set_evt & in_ring & ~disarm;
      act_set     = set_evt & ~in_ring;
`ifdef SNOOZE_EN
      snooze_req  = mode_press & in_ring;
`else
      snooze_req  = 1'b0;
`endif
      alarm_match = tick_1hz & (time_hh == alarm_hh) & (time_mm == alarm_mm)
                    & (time_ss == 8'd0);

      mode_nxt       = mode;
      inc_hh_nxt     = 1'b0;
      inc_mm_nxt     = 1'b0;
      inc_target_nxt = inc_target;
      sw_run_nxt     = sw_run;
      sw_clear_nxt   = 1'b0;
      state_nxt      = state;
      ring_cnt_nxt   = ring_cnt;
      phase_nxt      = phase;
`ifdef SNOOZE_EN
      snz_cnt_nxt    = snz_cnt;
`endif

      if (mode_press && !sw_edit && !snooze_req) begin
         mode_nxt = next_mode(mode);
      end

      if (act_set && sw_edit && (mode != STOPWATCH)) begin
         case (sw_field)
            FIELD_HH: inc_hh_nxt = 1'b1;
            FIELD_MM: inc_mm_nxt = 1'b1;
            default:  ;
         endcase
      end
      if (inc_hh_nxt || inc_mm_nxt) begin
         inc_target_nxt = mode;
      end
      arm_by_inc = (inc_hh_nxt | inc_mm_nxt) & (mode == ALARM);

      if (act_set && (mode == STOPWATCH)) begin
         if (sw_edit) begin
            sw_clear_nxt = 1'b1;
            sw_run_nxt   = 1'b0;
         end else begin
            sw_run_nxt   = ~sw_run;
         end
      end

      if (disarm) begin
         state_nxt    = ST_IDLE;
         ring_cnt_nxt = '0;
         phase_nxt    = 1'b0;
`ifdef SNOOZE_EN
         snz_cnt_nxt  = '0;
`endif
      end else if (dismiss) begin
         state_nxt    = ST_ARMED;
         ring_cnt_nxt = '0;
         phase_nxt    = 1'b0;
`ifdef SNOOZE_EN
      end else if (snooze_req) begin
         state_nxt    = ST_SNOOZE;
         ring_cnt_nxt = '0;
         phase_nxt    = 1'b0;
         snz_cnt_nxt  = '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (arm_toggle || arm_by_inc) begin
                  state_nxt = ST_ARMED;
               end
            end
            ST_ARMED: begin
               if (alarm_match) begin
                  state_nxt    = ST_RINGING;
                  ring_cnt_nxt = '0;
                  phase_nxt    = 1'b1;
               end
            end
            ST_RINGING: begin
               if (tick_1hz) begin
                  if (ring_cnt == RING_LAST) begin
                     state_nxt    = ST_ARMED;
                     ring_cnt_nxt = '0;
                     phase_nxt    = 1'b0;
                  end else begin
                     ring_cnt_nxt = ring_cnt + RW'(1);
                     phase_nxt    = ~phase;
                  end
               end
            end
`ifdef SNOOZE_EN
            ST_SNOOZE: begin
               if (tick_1hz) begin
                  if (snz_cnt == SNZ_LAST) begin
                     state_nxt    = ST_RINGING;
                     ring_cnt_nxt = '0;
                     phase_nxt    = 1'b1;
                     snz_cnt_nxt  = '0;
                  end else begin
                     snz_cnt_nxt  = snz_cnt + SW'(1);
                  end
               end
            end
`endif
            default: begin
               state_nxt    = ST_IDLE;
               ring_cnt_nxt = '0;
               phase_nxt    = 1'b0;
            end
         endcase
      end
   end

   // Register state and all outputs from their next values
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         ring_cnt    <= '0;
         phase       <= 1'b0;
         mode        <= CLOCK;
         inc_hh      <= 1'b0;
         inc_mm      <= 1'b0;
         inc_target  <= 2'd0;
         sw_run      <= 1'b0;
         sw_clear    <= 1'b0;
         alarm_armed <= 1'b0;
         ring        <= 1'b0;
         buzzer      <= 1'b0;
      end else begin
         state       <= state_nxt;
         ring_cnt    <= ring_cnt_nxt;
         phase       <= phase_nxt;
         mode        <= mode_nxt;
         inc_hh      <= inc_hh_nxt;
         inc_mm      <= inc_mm_nxt;
         inc_target  <= inc_target_nxt;
         sw_run      <= sw_run_nxt;
         sw_clear    <= sw_clear_nxt;
         alarm_armed <= (state_nxt != ST_IDLE);
         ring        <= (state_nxt == ST_RINGING);
         buzzer      <= (state_nxt == ST_RINGING) & phase_nxt;
      end
   end

`ifdef SNOOZE_EN
   // Snooze dwell counter
   always_ff @(posedge clk) begin
      if (rst) begin
         snz_cnt <= '0;
      end else begin
         snz_cnt <= snz_cnt_nxt;
      end
   end
`endif

endmodule : clock_mode_controller
`default_nettype wire

// File: tb/tb_clock_mode_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_mode_controller
// Description : Directed self-checking bench for clock_mode_controller with
//               DEBOUNCE_CYCLES=4, RING_SECONDS=3, SNOOZE_SECONDS=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_mode_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick_1hz = 1'b0;
   logic       btn_mode_n = 1'b1;
   logic       btn_set_n = 1'b1;
   logic       sw_edit = 1'b0;
   logic [1:0] sw_field = 2'b00;
   logic [7:0] time_hh = 8'd0;
   logic [7:0] time_mm = 8'd0;
   logic [7:0] time_ss = 8'd5;
   logic [7:0] alarm_hh = 8'd7;
   logic [7:0] alarm_mm = 8'd30;
   logic [1:0] mode;
   logic       inc_hh;
   logic       inc_mm;
   logic [1:0] inc_target;
   logic       sw_run;
   logic       sw_clear;
   logic       alarm_armed;
   logic       ring;
   logic       buzzer;

   int checks   = 0;
   int failures = 0;
   int n_hh     = 0;
   int n_mm     = 0;
   int n_clr    = 0;
   logic [1:0] tgt_seen = 2'd0;

   clock_mode_controller #(
      .DEBOUNCE_CYCLES (4),
      .RING_SECONDS    (3),
      .SNOOZE_SECONDS  (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .tick_1hz    (tick_1hz),
      .btn_mode_n  (btn_mode_n),
      .btn_set_n   (btn_set_n),
      .sw_edit     (sw_edit),
      .sw_field    (sw_field),
      .time_hh     (time_hh),
      .time_mm     (time_mm),
      .time_ss     (time_ss),
      .alarm_hh    (alarm_hh),
      .alarm_mm    (alarm_mm),
      .mode        (mode),
      .inc_hh      (inc_hh),
      .inc_mm      (inc_mm),
      .inc_target  (inc_target),
      .sw_run      (sw_run),
      .sw_clear    (sw_clear),
      .alarm_armed (alarm_armed),
      .ring        (ring),
      .buzzer      (buzzer)
   );

   always #5 clk = ~clk;

   // Count strobe pulses, sampled away from the active edge
   always @(negedge clk) begin
      if (inc_hh) n_hh <= n_hh + 1;
      if (inc_mm) begin
         n_mm     <= n_mm + 1;
         tgt_seen <= inc_target;
      end
      if (sw_clear) n_clr <= n_clr + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string pfx);
      chk({pfx, "_mode"},       32'(mode),        32'd0);
      chk({pfx, "_inc_hh"},     32'(inc_hh),      32'd0);
      chk({pfx, "_inc_mm"},     32'(inc_mm),      32'd0);
      chk({pfx, "_inc_target"}, 32'(inc_target),  32'd0);
      chk({pfx, "_sw_run"},     32'(sw_run),      32'd0);
      chk({pfx, "_sw_clear"},   32'(sw_clear),    32'd0);
      chk({pfx, "_armed"},      32'(alarm_armed), 32'd0);
      chk({pfx, "_ring"},       32'(ring),        32'd0);
      chk({pfx, "_buzzer"},     32'(buzzer),      32'd0);
   endtask

   // Clean press: 10 cycles low, then long enough released to settle
   task automatic press_mode();
      @(negedge clk) btn_mode_n = 1'b0;
      repeat (10) @(negedge clk);
      btn_mode_n = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   task automatic press_set();
      @(negedge clk) btn_set_n = 1'b0;
      repeat (10) @(negedge clk);
      btn_set_n = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   task automatic tick();
      @(negedge clk) tick_1hz = 1'b1;
      @(negedge clk) tick_1hz = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int hh0, mm0, clr0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_reset("reset");
      repeat (5) @(negedge clk);

      // 3-cycle glitch is filtered
      btn_mode_n = 1'b0;
      repeat (3) @(negedge clk);
      btn_mode_n = 1'b1;
      repeat (15) @(negedge clk);
      chk("glitch_mode", 32'(mode), 32'd0);

      // Clean press: mode updates exactly 7 edges after the raw edge
      btn_mode_n = 1'b0;
      repeat (6) @(posedge clk);
      #1 chk("latency_before", 32'(mode), 32'd0);
      @(posedge clk);
      #1 chk("latency_at", 32'(mode), 32'd1);
      repeat (4) @(negedge clk);
      btn_mode_n = 1'b1;
      repeat (12) @(negedge clk);

      press_mode(); chk("mode_step2", 32'(mode), 32'd2);
      press_mode(); chk("mode_step3", 32'(mode), 32'd3);
      press_mode(); chk("mode_wrap0", 32'(mode), 32'd0);

      // Editing blocks mode changes
      sw_edit = 1'b1;
      for (int i = 0; i < 4; i++) begin
         press_mode();
         chk("mode_edit_hold", 32'(mode), 32'd0);
      end

      // ALARM mode, edit minutes: one inc_mm, target ALARM, arms alarm
      sw_edit = 1'b0;
      press_mode();
      chk("mode_alarm", 32'(mode), 32'd1);
      sw_edit  = 1'b1;
      sw_field = 2'b10;
      hh0 = n_hh; mm0 = n_mm;
      press_set();
      chk("inc_mm_count", 32'(n_mm - mm0), 32'd1);
      chk("inc_hh_count", 32'(n_hh - hh0), 32'd0);
      chk("inc_target",   32'(tgt_seen),   32'd1);
      chk("armed_by_inc", 32'(alarm_armed), 32'd1);
      sw_edit  = 1'b0;
      sw_field = 2'b00;

      // Match at 07:30:00, buzzer cadence, auto-stop after 3 ticks
      time_hh = 8'd7; time_mm = 8'd30; time_ss = 8'd0;
      tick();
      chk("ring_rise",   32'(ring),   32'd1);
      chk("buzz_t0",     32'(buzzer), 32'd1);
      time_ss = 8'd1;
      tick();
      chk("ring_t1",     32'(ring),   32'd1);
      chk("buzz_t1",     32'(buzzer), 32'd0);
      tick();
      chk("buzz_t2",     32'(buzzer), 32'd1);
      tick();
      chk("autostop_ring",  32'(ring),        32'd0);
      chk("autostop_armed", 32'(alarm_armed), 32'd1);
      chk("autostop_buzz",  32'(buzzer),      32'd0);

      // Go to STOPWATCH, ring, then a set press only dismisses
      press_mode(); press_mode();
      chk("mode_sw", 32'(mode), 32'd3);
      time_ss = 8'd0;
      tick();
      time_ss = 8'd1;
      chk("ring_again", 32'(ring), 32'd1);
      press_set();
      chk("dismiss_ring",  32'(ring),        32'd0);
      chk("dismiss_armed", 32'(alarm_armed), 32'd1);
      chk("dismiss_run",   32'(sw_run),      32'd0);

      // Stopwatch run toggle and clear
      press_set();
      chk("run_on", 32'(sw_run), 32'd1);
      sw_edit = 1'b1;
      clr0 = n_clr;
      press_set();
      chk("clear_pulse", 32'(n_clr - clr0), 32'd1);
      chk("clear_stop",  32'(sw_run),        32'd0);
      sw_edit = 1'b0;
      press_set();
      chk("run_on2", 32'(sw_run), 32'd1);

      // Mode press while ringing
      time_ss = 8'd0;
      tick();
      time_ss = 8'd1;
      chk("ring_third", 32'(ring), 32'd1);
      press_mode();
`ifdef SNOOZE_EN
      chk("snz_mode",  32'(mode),        32'd3);
      chk("snz_ring",  32'(ring),        32'd0);
      chk("snz_armed", 32'(alarm_armed), 32'd1);
      tick();
      chk("snz_t1_ring", 32'(ring), 32'd0);
      tick();
      chk("snz_rering", 32'(ring),   32'd1);
      chk("snz_buzz",   32'(buzzer), 32'd1);
`else
      chk("modepress_ring_mode", 32'(mode), 32'd0);
      chk("modepress_ring_ring", 32'(ring), 32'd1);
`endif
      chk("run_kept", 32'(sw_run), 32'd1);

      // Reset while ringing with the stopwatch running
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      chk_reset("midring");

      // Button held through reset produces no press
      @(negedge clk) rst = 1'b1;
      btn_mode_n = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (15) @(negedge clk);
      chk("held_reset_mode", 32'(mode), 32'd0);
      btn_mode_n = 1'b1;
      repeat (12) @(negedge clk);
      press_mode();
      chk("after_release_mode", 32'(mode), 32'd1);

      // Arm toggle in ALARM mode, then disarm
      press_set();
      chk("toggle_arm",    32'(alarm_armed), 32'd1);
      press_set();
      chk("toggle_disarm", 32'(alarm_armed), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_clock_mode_controller
`default_nettype wire
